mux_16to1: RTL and testbench
============================

// Module: mux_16to1
// PURPOSE
//  - Registered 16-way word selector for the CPU datapath: routes one of 16 N-bit operand/result buses to out.
//  - The routing key is fn_sel, the 5-bit function-select code from the decoder.
//  - Codes 16..31 are out-of-range: out is forced to zero and an error flag is raised.
//  - One clock, synchronous active-high reset; one-cycle latency from fn_sel/aX to out.
// PARAMETERS
//  - N  default 16  width of each data input and of out (N >= 1)
// PORTS
//  - clk          in   1    clock, all state updates on rising edge
//  - rst          in   1    synchronous reset, active-high
//  - a0..a15      in   N    data inputs; index k selected when fn_sel == k
//  - fn_sel       in   5    select code; 0..15 valid, 16..31 out-of-range
//  - out          out  N    registered selected word
//  - sel_invalid  out  1    registered flag: previous-cycle fn_sel was >= 16
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
//  - Reset: on a rising edge with rst=1, out <= '0 and sel_invalid <= 0, regardless of other inputs.
//    - rst dominates any simultaneous select or data change.
//    - First non-reset edge after rst falls loads normally.
//  - Normal operation, every rising edge with rst=0:
//    - out <= a[fn_sel] when fn_sel <= 15, else out <= '0.
//    - sel_invalid <= (fn_sel[4] == 1).
//  - Latency: exactly 1 cycle. Inputs are sampled at edge t and visible at out after edge t.
//    - No combinational path from any input to any output.
//  - Data changes on the selected input while fn_sel is stable propagate on the next edge.
//  - Changes on unselected inputs never affect out.
//  - Out-of-range codes 16..31 all behave identically; no wrap-around (16 does NOT alias to a0).
//  - No handshake; output is valid every cycle after reset.
//  - X on fn_sel must not be masked: simulation may propagate X to out.
//  - Pure datapath: no state beyond the two output registers; no enables.
// STRUCTURE
//  - Shared package mux_pkg:
//    - localparam NUM_IN = 16
//    - localparam SEL_W = 5
//    - typedef logic [SEL_W-1:0] fn_sel_t
//  - Sub-module mux16_comb: purely combinational 16:1 select with zero default for out-of-range codes.
//  - Top level mux_16to1 instantiates mux16_comb and adds the output register and invalid flag.
// TESTING
//  - Directed scenarios:
//    1. Reset: drive rst=1 for 2 edges with a0..a15 random, fn_sel=3.
//       -> out==0, sel_invalid==0 after each edge.
//    2. Sweep: a_k = 16'h1000+k, fn_sel = 0..15 one per cycle.
//       -> out == 16'h1000+k one edge after each select; sel_invalid==0.
//    3. Out-of-range: fn_sel=16, then 31, with a0=16'hBEEF.
//       -> out==0 and sel_invalid==1 on both cycles.
//       -> Returning to fn_sel=0 gives out==16'hBEEF, sel_invalid==0.
//    4. Data tracking: fn_sel=5 held, a5 = 16'h00FF then 16'hFF00, a6 toggled.
//       -> out follows a5 with 1-cycle lag; a6 has no effect.
//    5. Reset mid-stream: fn_sel=7, a7=16'h1234, assert rst for one edge.
//       -> out==0 that cycle; next edge out==16'h1234.
//    6. Width: N=8 instance, a15 = 8'hA5, fn_sel=15.
//       -> out==8'hA5 after one edge.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the 16-way registered word selector.
//   NUM_IN   : number of selectable data inputs
//   SEL_W    : width of the function-select code
//   fn_sel_t : select-code type (codes >= NUM_IN are out-of-range)
package mux_pkg;

    localparam int unsigned NUM_IN = 16;
    localparam int unsigned SEL_W  = 5;

    typedef logic [SEL_W-1:0] fn_sel_t;

endpackage

// File: rtl/mux16_comb.sv
// Purely combinational 16:1 word select.
// Ports:
//   words  in   NUM_IN x N  packed data inputs, words[k] chosen when fn_sel == k
//   fn_sel in   SEL_W       select code, 0..15 valid, 16..31 out-of-range
//   y      out  N           selected word, zero for out-of-range codes
module mux16_comb
    import mux_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic [NUM_IN-1:0][N-1:0] words,
    input  fn_sel_t                  fn_sel,
    output logic [N-1:0]             y
);

    // A ternary is used instead of a case statement. An X on fn_sel then shows up
    // as X on y in simulation, rather than quietly falling into a default arm.
    always_comb begin
        y = fn_sel[SEL_W-1] ? '0 : words[fn_sel[SEL_W-2:0]];
    end

endmodule

// File: rtl/mux_16to1.sv
// Registered 16-way word selector for the CPU datapath.
// Latency is one cycle from fn_sel/aX to out.
// Ports:
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous reset, active-high
//   a0..a15      in   N  data inputs
//   fn_sel       in   5  select code, 0..15 valid, 16..31 force zero and flag
//   out          out  N  registered selected word
//   sel_invalid  out  1  registered flag, set when the previous fn_sel was >= 16
module mux_16to1
    import mux_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] a2,
    input  logic [N-1:0] a3,
    input  logic [N-1:0] a4,
    input  logic [N-1:0] a5,
    input  logic [N-1:0] a6,
    input  logic [N-1:0] a7,
    input  logic [N-1:0] a8,
    input  logic [N-1:0] a9,
    input  logic [N-1:0] a10,
    input  logic [N-1:0] a11,
    input  logic [N-1:0] a12,
    input  logic [N-1:0] a13,
    input  logic [N-1:0] a14,
    input  logic [N-1:0] a15,
    input  fn_sel_t      fn_sel,
    output logic [N-1:0] out,
    output logic         sel_invalid
);

    logic [NUM_IN-1:0][N-1:0] words;
    logic [N-1:0]             sel_word;

    assign words = {a15, a14, a13, a12, a11, a10, a9, a8,
                    a7,  a6,  a5,  a4,  a3,  a2,  a1, a0};

    mux16_comb #(
        .N (N)
    ) u_mux16_comb (
        .words  (words),
        .fn_sel (fn_sel),
        .y      (sel_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out         <= '0;
            sel_invalid <= 1'b0;
        end else begin
            out         <= sel_word;
            sel_invalid <= fn_sel[SEL_W-1];
        end
    end

endmodule

// File: tb/tb_mux_16to1.sv
// Self-checking bench for mux_16to1. It drives an N=16 instance and an N=8
// instance, and compares both against a select-by-index reference model.
module tb_mux_16to1;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a [16];
    logic [4:0]  fn_sel;
    logic [15:0] out;
    logic        sel_invalid;

    logic [7:0]  b [16];
    logic [4:0]  fn_sel8;
    logic [7:0]  out8;
    logic        sel_invalid8;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mux_16to1 #(.N(16)) dut (
        .clk(clk), .rst(rst),
        .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]),
        .a4(a[4]), .a5(a[5]), .a6(a[6]), .a7(a[7]),
        .a8(a[8]), .a9(a[9]), .a10(a[10]), .a11(a[11]),
        .a12(a[12]), .a13(a[13]), .a14(a[14]), .a15(a[15]),
        .fn_sel(fn_sel), .out(out), .sel_invalid(sel_invalid)
    );

    mux_16to1 #(.N(8)) dut8 (
        .clk(clk), .rst(rst),
        .a0(b[0]), .a1(b[1]), .a2(b[2]), .a3(b[3]),
        .a4(b[4]), .a5(b[5]), .a6(b[6]), .a7(b[7]),
        .a8(b[8]), .a9(b[9]), .a10(b[10]), .a11(b[11]),
        .a12(b[12]), .a13(b[13]), .a14(b[14]), .a15(b[15]),
        .fn_sel(fn_sel8), .out(out8), .sel_invalid(sel_invalid8)
    );

    // Reference model: index into the input array, or zero when the code is out of range.
    function automatic logic [15:0] model16(input int sel, input logic [15:0] w [16]);
        return (sel < 16) ? w[sel] : 16'h0000;
    endfunction

    function automatic logic [7:0] model8(input int sel, input logic [7:0] w [16]);
        return (sel < 16) ? w[sel] : 8'h00;
    endfunction

    // Advance past the next rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < 16; k++) begin
            a[k] = 16'($urandom);
            b[k] = 8'($urandom);
        end
    endtask

    task automatic test_reset();
        randomize_inputs();
        fn_sel  = 5'd3;
        fn_sel8 = 5'd3;
        rst     = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if (out !== 16'h0000 || sel_invalid !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: out=%h inv=%b, required out=0000 inv=0",
                         i, out, sel_invalid);
            end
            vectors++;
            if (out8 !== 8'h00 || sel_invalid8 !== 1'b0) begin
                errors++;
                $display("FAIL reset8[%0d]: out=%h inv=%b, required out=00 inv=0",
                         i, out8, sel_invalid8);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        for (int k = 0; k < 16; k++) a[k] = 16'h1000 + 16'(k);
        for (int k = 0; k < 16; k++) begin
            fn_sel = 5'(k);
            step();
            vectors++;
            if (out !== 16'h1000 + 16'(k) || sel_invalid !== 1'b0) begin
                errors++;
                $display("FAIL sweep[%0d]: out=%h inv=%b, required out=%h inv=0",
                         k, out, sel_invalid, 16'h1000 + 16'(k));
            end
        end
    endtask

    task automatic test_out_of_range();
        int codes [2] = '{16, 31};
        a[0] = 16'hBEEF;
        foreach (codes[i]) begin
            fn_sel = 5'(codes[i]);
            step();
            vectors++;
            if (out !== 16'h0000 || sel_invalid !== 1'b1) begin
                errors++;
                $display("FAIL oor[%0d]: out=%h inv=%b, required out=0000 inv=1",
                         codes[i], out, sel_invalid);
            end
        end
        fn_sel = 5'd0;
        step();
        vectors++;
        if (out !== 16'hBEEF || sel_invalid !== 1'b0) begin
            errors++;
            $display("FAIL oor_return: out=%h inv=%b, required out=beef inv=0", out, sel_invalid);
        end
    endtask

    task automatic test_data_tracking();
        logic [15:0] vals [3] = '{16'h00FF, 16'hFF00, 16'hFF00};
        fn_sel = 5'd5;
        a[6]   = 16'h5A5A;
        foreach (vals[i]) begin
            a[5] = vals[i];
            a[6] = ~a[6];
            step();
            vectors++;
            if (out !== vals[i] || sel_invalid !== 1'b0) begin
                errors++;
                $display("FAIL track[%0d]: out=%h inv=%b, required out=%h inv=0",
                         i, out, sel_invalid, vals[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp [3] = '{16'h1234, 16'h0000, 16'h1234};
        fn_sel = 5'd7;
        a[7]   = 16'h1234;
        foreach (exp[i]) begin
            rst = (i == 1);
            step();
            vectors++;
            if (out !== exp[i] || sel_invalid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid[%0d]: out=%h inv=%b, required out=%h inv=0",
                         i, out, sel_invalid, exp[i]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_width();
        b[15]   = 8'hA5;
        b[14]   = 8'h5A;
        fn_sel8 = 5'd15;
        step();
        vectors++;
        if (out8 !== 8'hA5 || sel_invalid8 !== 1'b0) begin
            errors++;
            $display("FAIL width8: out=%h inv=%b, required out=a5 inv=0", out8, sel_invalid8);
        end
    endtask

    task automatic test_random();
        logic [15:0] e16;
        logic [7:0]  e8;
        logic        einv;
        logic        einv8;
        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            fn_sel  = 5'($urandom_range(0, 31));
            fn_sel8 = 5'($urandom_range(0, 31));
            rst     = ($urandom_range(0, 15) == 0);
            e16   = rst ? 16'h0 : model16(int'(fn_sel), a);
            e8    = rst ? 8'h0 : model8(int'(fn_sel8), b);
            einv  = !rst && (fn_sel >= 5'd16);
            einv8 = !rst && (fn_sel8 >= 5'd16);
            step();
            vectors++;
            if (out !== e16 || sel_invalid !== einv) begin
                errors++;
                $display("FAIL random16[%0d]: sel=%0d rst=%b out=%h inv=%b, required out=%h inv=%b",
                         i, fn_sel, rst, out, sel_invalid, e16, einv);
            end
            vectors++;
            if (out8 !== e8 || sel_invalid8 !== einv8) begin
                errors++;
                $display("FAIL random8[%0d]: sel=%0d rst=%b out=%h inv=%b, required out=%h inv=%b",
                         i, fn_sel8, rst, out8, sel_invalid8, e8, einv8);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        fn_sel  = 5'd0;
        fn_sel8 = 5'd0;
        for (int k = 0; k < 16; k++) begin
            a[k] = '0;
            b[k] = '0;
        end
        #2;
        test_reset();
        test_sweep();
        test_out_of_range();
        test_data_tracking();
        test_reset_mid();
        test_width();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
